// File: rtl/uart_tx_buffer.sv
// rtl/uart_tx_buffer.sv - FIFO-buffered start/done front-end for the UART transmitter
// Optional feature macro: UART_TX_BUF_CRLF_EN (insert CR before each LF on the output side)
module uart_tx_buffer #(
  parameter int DATA_BITS  = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_wr_en,
  input  logic [DATA_BITS-1:0]  i_wr_data,
  output logic                  o_full,
  output logic                  o_empty,
  output logic [DEPTH_LOG2:0]   o_count,
  output logic                  o_overflow,
  output logic                  o_tx_start,
  output logic [DATA_BITS-1:0]  o_tx_data,
  input  logic                  i_tx_done,
  output logic                  o_busy
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   CNT_FULL = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  logic [DATA_BITS-1:0]  mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q;
  logic [DEPTH_LOG2-1:0] rd_ptr_q;
  logic [DEPTH_LOG2:0]   count_q;
  logic [DEPTH_LOG2:0]   count_d;
  logic                  full_q;
  logic                  empty_q;
  logic                  overflow_q;
  state_t                state_q;
  logic                  tx_start_q;
  logic [DATA_BITS-1:0]  tx_data_q;
  logic                  busy_q;
  logic                  push;
  logic                  pop;
  logic [DATA_BITS-1:0]  head;

  assign head = mem_q[rd_ptr_q];
  assign push = i_wr_en && !full_q;

`ifdef UART_TX_BUF_CRLF_EN
  localparam logic [DATA_BITS-1:0] CHAR_LF = DATA_BITS'('h0A);
  localparam logic [DATA_BITS-1:0] CHAR_CR = DATA_BITS'('h0D);
  logic cr_sent_q;
  logic insert_cr;

  // A head LF without a preceding CR yet gets a CR first and stays in the FIFO
  assign insert_cr = (head == CHAR_LF) && !cr_sent_q;
  assign pop       = (state_q == S_IDLE) && !empty_q && !insert_cr;
`else
  assign pop       = (state_q == S_IDLE) && !empty_q;
`endif

  // Occupancy after this edge; a simultaneous push and pop cancel out
  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CNT_ONE;
    end else if (pop && !push) begin
      count_d = count_q - CNT_ONE;
    end
  end

  // Storage array needs no reset: entries are only read once written
  always_ff @(posedge i_clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= i_wr_data;
    end
  end

  // Pointers, occupancy flags and the sticky overflow flag
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
      if (i_wr_en && full_q) begin
        overflow_q <= 1'b1;
      end
      count_q <= count_d;
      full_q  <= (count_d == CNT_FULL);
      empty_q <= (count_d == '0);
    end
  end

  // Transmit sequencer: load head byte, pulse start for one cycle, wait for done
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      busy_q     <= 1'b0;
`ifdef UART_TX_BUF_CRLF_EN
      cr_sent_q  <= 1'b0;
`endif
    end else begin
      tx_start_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (!empty_q) begin
`ifdef UART_TX_BUF_CRLF_EN
            if (insert_cr) begin
              tx_data_q <= CHAR_CR;
              cr_sent_q <= 1'b1;
            end else begin
              tx_data_q <= head;
              cr_sent_q <= 1'b0;
            end
`else
            tx_data_q  <= head;
`endif
            tx_start_q <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= S_START;
          end
        end
        S_START: begin
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (i_tx_done) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign o_full     = full_q;
  assign o_empty    = empty_q;
  assign o_count    = count_q;
  assign o_overflow = overflow_q;
  assign o_tx_start = tx_start_q;
  assign o_tx_data  = tx_data_q;
  assign o_busy     = busy_q;

endmodule

// File: doc/uart_tx_buffer.md
# uart_tx_buffer

Buffered transmit front-end for the UART. It accepts bytes from the calculator core at any rate up to one per clock and stores them in a FIFO. It then feeds them one at a time into the UART transmitter's start/done handshake, so the core never stalls on a serial frame. It drives `i_tx_start`/`i_data` of `uart` and consumes its `o_tx_done`.

## Interface

Parameters:
- `DATA_BITS`, 8: byte width; must match `uart`.
- `DEPTH_LOG2`, 4: FIFO depth is 2^DEPTH_LOG2 entries (16 by default).

Ports:
- `i_clk` in 1: system clock (100 MHz).
- `i_rst` in 1: reset, asynchronous, active-high.
- `i_wr_en` in 1: write strobe; a byte is accepted on each clock edge where this is high.
- `i_wr_data` in DATA_BITS: byte to enqueue.
- `o_full` out 1: FIFO holds 2^DEPTH_LOG2 entries.
- `o_empty` out 1: FIFO holds 0 entries.
- `o_count` out DEPTH_LOG2+1: current number of occupied FIFO entries.
- `o_overflow` out 1: sticky flag; set when a write is dropped.
- `o_tx_start` out 1: one-cycle start pulse to the UART transmitter.
- `o_tx_data` out DATA_BITS: byte being transmitted; held stable from start until done.
- `i_tx_done` in 1: one-cycle pulse from the UART transmitter after the stop bit.
- `o_busy` out 1: the FSM is not in IDLE.

## Operation

- FIFO: circular buffer with read and write pointers of DEPTH_LOG2 bits. The pointers wrap modulo depth. `o_count` is a separate counter.
- Write: if `i_wr_en` is high and `o_full` is low (value before the edge), store `i_wr_data` and increment the count.
- Overflow: if `i_wr_en` is high while `o_full` is high, drop the byte and set `o_overflow`. This holds even if a pop occurs on the same edge.
- Pop: done only by the FSM, and only when not empty. A write and a pop on the same edge leave the count unchanged.
- FSM states:
  - IDLE: if the FIFO is not empty, register the head byte into `o_tx_data`, pop it, and go to START.
  - START: `o_tx_start`=1 for exactly this one cycle; then go to WAIT.
  - WAIT: on `i_tx_done`, go to IDLE; otherwise stay.
- `i_tx_done` is ignored in IDLE and START.
- `o_tx_data` changes only on the IDLE→START transition.
- Reset mid-operation: the FIFO is flushed, the FSM returns to IDLE, and `o_tx_start` drops immediately. The UART shares `i_rst`, so an in-flight frame is aborted as well.

## Timing

- Reset values: `o_full`=0, `o_empty`=1, `o_count`=0, `o_overflow`=0, `o_tx_start`=0, `o_tx_data`=0, `o_busy`=0. The FSM is in IDLE and both pointers are 0.
- Latency: for a write at edge E into an empty FIFO with the FSM in IDLE:
  - `o_empty` falls after E.
  - The FSM pops at E+1.
  - `o_tx_start` is high during the cycle between E+1 and E+2.
- Back-to-back bytes: after `i_tx_done` at edge D, the next `o_tx_start` is high between D+1 and D+2. This gives a 2-cycle turnaround, negligible against the 868-cycle bit time.
- `o_full`, `o_empty`, and `o_count` are registered and reflect the state after each edge.

## Configuration

- `UART_TX_BUF_CRLF_EN`, when defined:
  - In IDLE, if the head byte is 0x0A and the internal `cr_sent` flag is clear, the FSM loads 0x0D without popping and sets `cr_sent`.
  - On the next IDLE visit it loads 0x0A, pops, and clears `cr_sent`.
  - The LF occupies one FIFO entry; the CR is generated on the output side only.
  - Reset clears `cr_sent`.
- Not defined: bytes are sent verbatim, and no `cr_sent` logic exists.

## Test plan

- Reset, then write 0x41 once → `o_tx_start` pulses for 1 cycle at E+1..E+2 with `o_tx_data`=0x41. No further start until `i_tx_done`, after which the FSM is in IDLE and `o_busy`=0.
- Hold `i_tx_done` low and write 0x00..0x10 (17 bytes) back-to-back. The first byte is popped, so the 17th write is accepted and `o_full`=1. An 18th write of 0x11 is dropped and sets `o_overflow`=1. Draining yields 0x00..0x10 in order, and `o_overflow` stays 1.
- Pointer wrap: write 10, drain 10, write 12 → output order is preserved and `o_count` tracks exactly, peaking at ≤12.
- Write 0x41, 0x0A:
  - with `UART_TX_BUF_CRLF_EN`, the transmitted sequence is 0x41, 0x0D, 0x0A (3 starts);
  - without it, the sequence is 0x41, 0x0A (2 starts).
- Assert `i_rst` during WAIT with 5 bytes queued → `o_tx_start`=0, `o_count`=0, `o_empty`=1, `o_overflow`=0. A later write of 0x55 is sent normally.
- Pulse `i_tx_done` in IDLE with the FIFO empty, and in START → no state change and no extra pop.
